// File: rtl/irrigation_zone_scheduler_pkg.sv
// Shared types and helpers for the irrigation zone scheduler.
package irrigation_zone_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IRRIGATE = 2'd1,
        SETTLE   = 2'd2,
        FAULT    = 2'd3
    } state_e;

    // A probe can only be submerged if every probe below it is submerged too;
    // anything else means a stuck or broken level sensor.
    function automatic logic conflicting_values(input logic low_lvl,
                                                input logic mid_lvl,
                                                input logic high_lvl);
        return (high_lvl & ~mid_lvl) | (mid_lvl & ~low_lvl);
    endfunction

endpackage

// File: rtl/irrigation_zone_scheduler_round_robin_zone_picker.sv
// Round-robin search for the next dry zone, starting just after the last one served.
module round_robin_zone_picker #(
    parameter int ZONES = 4,
    parameter int IDX_W = (ZONES > 1) ? $clog2(ZONES) : 1
) (
    input  logic [ZONES-1:0] request,
    input  logic [IDX_W-1:0] last_zone,
    output logic [ZONES-1:0] grant,
    output logic             valid
);

    // Scan last_zone+1 .. last_zone+ZONES (mod ZONES) and grant the first requester
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx   = '0;
        grant = '0;
        valid = 1'b0;
        for (int off = 1; off <= ZONES; off++) begin
            idx = IDX_W'((int'(last_zone) + off) % ZONES);
            if (!valid && request[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Irrigation zone scheduler: one zone at a time, sprinkler or dripper mode,
// settle time between zones, reservoir refill hysteresis and sensor fault handling.
module irrigation_zone_scheduler
    import irrigation_zone_scheduler_pkg::*;
#(
    parameter int ZONES             = 4,
    parameter int TIMER_WIDTH       = 8,
    parameter int SPRINKLER_SECONDS = 10,
    parameter int DRIPPER_SECONDS   = 20,
    parameter int SETTLE_SECONDS    = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   tick,
    input  logic                   low_water_level,
    input  logic                   mid_water_level,
    input  logic                   high_water_level,
    input  logic [ZONES-1:0]       earth_humidity,
    input  logic                   air_humidity,
    input  logic                   low_temperature,
    output logic                   splinker_bomb,
    output logic [ZONES-1:0]       dripper_valvule,
    output logic [ZONES-1:0]       zone_select,
    output logic [TIMER_WIDTH-1:0] remaining_seconds,
    output logic                   water_supply_valvule,
    output logic                   alarm,
    output logic                   busy
);

    localparam int IDX_W = (ZONES > 1) ? $clog2(ZONES) : 1;

    if ((ZONES < 2) || (ZONES > 8)) begin : g_bad_zones
        $error("ZONES must be in 2..8");
    end
    if ((SPRINKLER_SECONDS > (2**TIMER_WIDTH) - 1) ||
        (DRIPPER_SECONDS   > (2**TIMER_WIDTH) - 1) ||
        (SETTLE_SECONDS    > (2**TIMER_WIDTH) - 1)) begin : g_bad_load
        $error("timer load value does not fit in TIMER_WIDTH bits");
    end

    localparam logic [TIMER_WIDTH-1:0] SPRINKLER_LOAD = TIMER_WIDTH'(SPRINKLER_SECONDS);
    localparam logic [TIMER_WIDTH-1:0] DRIPPER_LOAD   = TIMER_WIDTH'(DRIPPER_SECONDS);
    localparam logic [TIMER_WIDTH-1:0] SETTLE_LOAD    = TIMER_WIDTH'(SETTLE_SECONDS);

    state_e                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   sprinkler_q, sprinkler_d;
    logic [IDX_W-1:0]       last_zone_q, last_zone_d;
    logic [ZONES-1:0]       zone_select_q, zone_select_d;
    logic [ZONES-1:0]       valve_q, valve_d;
    logic                   pump_q, pump_d;
    logic                   refill_q, refill_d;
    logic                   alarm_q, alarm_d;
    logic                   busy_q, busy_d;

    logic                   conflict;
    logic [ZONES-1:0]       pick_grant;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic [ZONES-1:0]       zone_d;
    logic                   irrigating_d;

    round_robin_zone_picker #(
        .ZONES (ZONES),
        .IDX_W (IDX_W)
    ) u_picker (
        .request   (~earth_humidity),
        .last_zone (last_zone_q),
        .grant     (pick_grant),
        .valid     (pick_valid)
    );

    // Encode the one-hot grant back to an index for last_zone bookkeeping
    always_comb begin
        pick_idx = '0;
        for (int z = 0; z < ZONES; z++) begin
            if (pick_grant[z]) begin
                pick_idx = IDX_W'(z);
            end
        end
    end

    // Next-state, timer and registered-output decode
    always_comb begin
        conflict    = conflicting_values(low_water_level, mid_water_level, high_water_level);
        state_d     = state_q;
        timer_d     = timer_q;
        sprinkler_d = sprinkler_q;
        last_zone_d = last_zone_q;
        zone_d      = zone_select_q;

        if (conflict) begin
            state_d = FAULT;
            timer_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (low_water_level && pick_valid) begin
                        state_d     = IRRIGATE;
                        zone_d      = pick_grant;
                        last_zone_d = pick_idx;
                        sprinkler_d = !air_humidity && !low_temperature && mid_water_level;
                        timer_d     = sprinkler_d ? SPRINKLER_LOAD : DRIPPER_LOAD;
                    end
                end
                IRRIGATE: begin
                    if (!low_water_level) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else if (|(earth_humidity & zone_select_q)) begin
                        state_d = SETTLE;
                        timer_d = SETTLE_LOAD;
                    end else if (tick) begin
                        if (timer_q <= TIMER_WIDTH'(1)) begin
                            state_d = SETTLE;
                            timer_d = SETTLE_LOAD;
                        end else begin
                            timer_d = timer_q - TIMER_WIDTH'(1);
                        end
                    end
                end
                SETTLE: begin
                    if (tick) begin
                        if (timer_q <= TIMER_WIDTH'(1)) begin
                            state_d = IDLE;
                            timer_d = '0;
                        end else begin
                            timer_d = timer_q - TIMER_WIDTH'(1);
                        end
                    end
                end
                FAULT: begin
                    if (tick) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with state_q
        irrigating_d  = (state_d == IRRIGATE);
        zone_select_d = irrigating_d ? zone_d : '0;
        pump_d        = irrigating_d && sprinkler_d;
        valve_d       = (irrigating_d && !sprinkler_d) ? zone_d : '0;
        busy_d        = (state_d == IRRIGATE) || (state_d == SETTLE);
        alarm_d       = (state_d == FAULT) || !mid_water_level;

        // Refill hysteresis: open below mid, close at high, always closed in fault
        refill_d = refill_q;
        if (!mid_water_level) begin
            refill_d = 1'b1;
        end
        if (high_water_level) begin
            refill_d = 1'b0;
        end
        if (state_d == FAULT) begin
            refill_d = 1'b0;
        end
    end

    // State and output registers; async reset closes every valve immediately
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            sprinkler_q   <= 1'b0;
            last_zone_q   <= IDX_W'(ZONES - 1);
            zone_select_q <= '0;
            valve_q       <= '0;
            pump_q        <= 1'b0;
            refill_q      <= 1'b0;
            alarm_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            sprinkler_q   <= sprinkler_d;
            last_zone_q   <= last_zone_d;
            zone_select_q <= zone_select_d;
            valve_q       <= valve_d;
            pump_q        <= pump_d;
            refill_q      <= refill_d;
            alarm_q       <= alarm_d;
            busy_q        <= busy_d;
        end
    end

    assign splinker_bomb        = pump_q;
    assign dripper_valvule      = valve_q;
    assign zone_select          = zone_select_q;
    assign remaining_seconds    = timer_q;
    assign water_supply_valvule = refill_q;
    assign alarm                = alarm_q;
    assign busy                 = busy_q;

endmodule

// File: doc/irrigation_zone_scheduler.md
IRRIGATION_ZONE_SCHEDULER -- requirements
Module: irrigation_zone_scheduler

Interface
REQ-001 Parameters SHALL be: ZONES, default 4, number of irrigation zones (2..8); TIMER_WIDTH, default 8, countdown width in bits; SPRINKLER_SECONDS, default 10, sprinkler run time; DRIPPER_SECONDS, default 20, dripper run time; SETTLE_SECONDS, default 2, dead time between zones.
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
REQ-003 clock  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 tick  in  1  one-clock 1 Hz enable; all timers count only on tick.
REQ-006 low_water_level, mid_water_level, high_water_level  in  1 each  reservoir probes; 1 = submerged.
REQ-007 earth_humidity  in  ZONES  per-zone soil probe; 1 = wet.
REQ-008 air_humidity, low_temperature  in  1 each  climate sensors; 1 = humid / cold.
REQ-009 splinker_bomb  out  1  sprinkler pump enable.
REQ-010 dripper_valvule  out  ZONES  per-zone dripper valve, one-hot or zero.
REQ-011 zone_select  out  ZONES  one-hot active zone, zero when idle.
REQ-012 remaining_seconds  out  TIMER_WIDTH  current countdown value.
REQ-013 water_supply_valvule  out  1  reservoir refill valve.
REQ-014 alarm  out  1  fault or low-reservoir indication.
REQ-015 busy  out  1  high in IRRIGATE or SETTLE.

Function
REQ-016 conflicting_values SHALL be (high & ~mid) | (mid & ~low), evaluated combinationally every cycle.
REQ-017 FSM states SHALL be IDLE, IRRIGATE, SETTLE, FAULT; all outputs registered.
REQ-018 Any state SHALL go to FAULT the cycle after conflicting_values=1; FAULT SHALL turn off pump, valves, zone_select, refill valve; alarm=1; remaining_seconds=0.
REQ-019 FAULT SHALL return to IDLE on the first tick with conflicting_values=0.
REQ-020 IDLE SHALL go to IRRIGATE in the next cycle when low_water_level=1 and any earth_humidity bit is 0; else remain in IDLE.
REQ-021 Zone choice SHALL be round-robin: first dry zone searching upward from last_zone+1, wrapping modulo ZONES; last_zone SHALL update on entry to IRRIGATE.
REQ-022 Mode SHALL be latched on entry to IRRIGATE: sprinkler if air_humidity=0, low_temperature=0, mid_water_level=1; else dripper. It SHALL not change mid-run.
REQ-023 On entry to IRRIGATE, remaining_seconds SHALL load SPRINKLER_SECONDS or DRIPPER_SECONDS; each tick SHALL decrement it.
REQ-024 In IRRIGATE, a tick with remaining_seconds=1 SHALL go to SETTLE and load SETTLE_SECONDS.
REQ-025 Early end SHALL apply: the selected zone's earth_humidity=1 goes to SETTLE next cycle; low_water_level=0 goes to IDLE next cycle; neither waits for tick.
REQ-026 In SETTLE, a tick with remaining_seconds=1 SHALL go to IDLE; no outputs are driven in SETTLE except busy.
REQ-027 In IRRIGATE, splinker_bomb=1 in sprinkler mode, or dripper_valvule equal to zone_select in dripper mode; never both.
REQ-028 water_supply_valvule SHALL use hysteresis: set when mid_water_level=0, clear when high_water_level=1, forced 0 in FAULT; it is independent of the irrigation FSM otherwise.
REQ-029 alarm SHALL be 1 in FAULT or when mid_water_level=0.
REQ-030 Load values exceeding 2^TIMER_WIDTH-1 SHALL be rejected at elaboration.

Reset
REQ-031 On reset_n=0: state IDLE, last_zone ZONES-1 (first search starts at zone 0), all outputs 0, timer 0.
REQ-032 Reset asserted mid-IRRIGATE SHALL close all valves and stop the pump immediately, without waiting for clock.

Structure
REQ-033 The state enumeration and the conflicting_values function SHALL reside in the shared irrigation package.
REQ-034 The round-robin dry-zone search SHALL be a sub-module round_robin_zone_picker (ZONES parameter, inputs request and last_zone, outputs one-hot grant and valid).

Verification
REQ-035 Defaults; levels low=mid=1; earth=4'b1010; air=0, cold=0 -> zone 0 sprinkler 10 ticks, SETTLE 2 ticks, then zone 2 sprinkler.
REQ-036 Air humidity 1 -> dripper_valvule=4'b0001 for 20 ticks, splinker_bomb stays 0.
REQ-037 Zone 0 earth to 1 at remaining=5 -> SETTLE next cycle, remaining=2.
REQ-038 high=1, mid=0 mid-run -> FAULT next cycle, all outputs 0, alarm=1; cleared on next tick -> IDLE.
REQ-039 mid falls 1->0 -> refill valve 1; high rises -> refill valve 0; mid returning alone keeps it 1.
REQ-040 Only zone 3 dry, last_zone=3 -> wrap search re-selects zone 3; reset_n pulse mid-run -> all outputs 0 asynchronously.
